// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encodings and widths for the pipeline-control block
package pipe_pkg;

    localparam int REG_ID_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dmem_state_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use compare between the EX load destination and the ID sources
module hazard_detect #(
    parameter int REG_ID_W = 3
) (
    input  logic [REG_ID_W-1:0] if_id_Rs,
    input  logic [REG_ID_W-1:0] if_id_Rt,
    input  logic                if_id_useRs,
    input  logic                if_id_useRt,
    input  logic                id_ex_MemRead,
    input  logic                id_ex_RegWrite,
    input  logic [REG_ID_W-1:0] id_ex_writeRegSel,
    output logic                ld_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit = if_id_useRs && (id_ex_writeRegSel == if_id_Rs);
        rt_hit = if_id_useRt && (id_ex_writeRegSel == if_id_Rt);
        ld_use = id_ex_MemRead && id_ex_RegWrite && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/reg_16b.sv
// rtl/reg_16b.sv - generic enabled register with synchronous active-high clear to zero
module reg_16b #(
    parameter int REG_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                write_en,
    input  logic [REG_SIZE-1:0] data_in,
    output logic [REG_SIZE-1:0] data_out
);

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (write_en) begin
            data_out <= data_in;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush/halt control; STALL_CNT_EN adds stall counters
module pipe_ctrl #(
    parameter int REG_ID_W = pipe_pkg::REG_ID_W,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ID_W-1:0] if_id_Rs,
    input  logic [REG_ID_W-1:0] if_id_Rt,
    input  logic                if_id_useRs,
    input  logic                if_id_useRt,
    input  logic                id_Halt,
    input  logic                id_ex_MemRead,
    input  logic                id_ex_RegWrite,
    input  logic [REG_ID_W-1:0] id_ex_writeRegSel,
    input  logic                ex_Taken,
    input  logic                ex_mem_MemRead,
    input  logic                ex_mem_MemWrite,
    input  logic                mem_Done,
    input  logic                mem_wb_Halt,
    output logic                PCStall,
    output logic                IFIDStall,
    output logic                FlushIFID,
    output logic                Flush,
    output logic                DMemStall,
    output logic                halt_done,
    output logic [CNT_W-1:0]    ld_use_cnt,
    output logic [CNT_W-1:0]    dmem_stall_cnt
);

    import pipe_pkg::*;

    dmem_state_e dstate_q;
    dmem_state_e dstate_d;
    halt_state_e hstate_q;
    halt_state_e hstate_d;
    logic        dstate_raw;
    logic [1:0]  hstate_raw;
    logic        ld_use;
    logic        mem_req;
    logic        ld_stall;

    hazard_detect #(
        .REG_ID_W(REG_ID_W)
    ) u_hazard_detect (
        .if_id_Rs          (if_id_Rs),
        .if_id_Rt          (if_id_Rt),
        .if_id_useRs       (if_id_useRs),
        .if_id_useRt       (if_id_useRt),
        .id_ex_MemRead     (id_ex_MemRead),
        .id_ex_RegWrite    (id_ex_RegWrite),
        .id_ex_writeRegSel (id_ex_writeRegSel),
        .ld_use            (ld_use)
    );

    reg_16b #(
        .REG_SIZE(1)
    ) u_dstate_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .data_in  (dstate_d),
        .data_out (dstate_raw)
    );

    reg_16b #(
        .REG_SIZE(2)
    ) u_hstate_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (1'b1),
        .data_in  (hstate_d),
        .data_out (hstate_raw)
    );

    assign dstate_q = dmem_state_e'(dstate_raw);
    assign hstate_q = halt_state_e'(hstate_raw);

    always_comb begin
        dstate_d  = dstate_q;
        hstate_d  = hstate_q;
        DMemStall = 1'b0;
        mem_req   = ex_mem_MemRead || ex_mem_MemWrite;

        case (dstate_q)
            IDLE: begin
                DMemStall = mem_req && !mem_Done;
                if (mem_req && !mem_Done) begin
                    dstate_d = BUSY;
                end
            end
            BUSY: begin
                DMemStall = !mem_Done;
                if (mem_Done) begin
                    dstate_d = IDLE;
                end
            end
            default: dstate_d = IDLE;
        endcase

        // A HALT seen under a taken branch is wrong-path; ex_Taken is ignored once draining.
        case (hstate_q)
            RUN: begin
                if (id_Halt && !ex_Taken && !DMemStall) begin
                    hstate_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_wb_Halt && !DMemStall) begin
                    hstate_d = HALTED;
                end
            end
            HALTED:  hstate_d = HALTED;
            default: hstate_d = RUN;
        endcase

        ld_stall  = ld_use && !ex_Taken;
        FlushIFID = ex_Taken;
        Flush     = ex_Taken || ld_use;
        IFIDStall = ld_stall || DMemStall;
        PCStall   = ld_stall || DMemStall || (hstate_q != RUN);
        halt_done = (hstate_q == HALTED);
    end

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] ld_use_cnt_d;
    logic [CNT_W-1:0] ld_use_cnt_q;
    logic [CNT_W-1:0] dmem_stall_cnt_d;
    logic [CNT_W-1:0] dmem_stall_cnt_q;
    logic             cnt_en;

    // Counters saturate rather than wrap so a long run never reads back as small.
    always_comb begin
        cnt_en           = (hstate_q != HALTED);
        ld_use_cnt_d     = ld_use_cnt_q;
        dmem_stall_cnt_d = dmem_stall_cnt_q;
        if (ld_stall && !DMemStall && (ld_use_cnt_q != {CNT_W{1'b1}})) begin
            ld_use_cnt_d = ld_use_cnt_q + 1'b1;
        end
        if (DMemStall && (dmem_stall_cnt_q != {CNT_W{1'b1}})) begin
            dmem_stall_cnt_d = dmem_stall_cnt_q + 1'b1;
        end
    end

    reg_16b #(
        .REG_SIZE(CNT_W)
    ) u_ld_use_cnt_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (cnt_en),
        .data_in  (ld_use_cnt_d),
        .data_out (ld_use_cnt_q)
    );

    reg_16b #(
        .REG_SIZE(CNT_W)
    ) u_dmem_stall_cnt_reg (
        .clk      (clk),
        .rst      (rst),
        .write_en (cnt_en),
        .data_in  (dmem_stall_cnt_d),
        .data_out (dmem_stall_cnt_q)
    );

    assign ld_use_cnt     = ld_use_cnt_q;
    assign dmem_stall_cnt = dmem_stall_cnt_q;
`else
    assign ld_use_cnt     = '0;
    assign dmem_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl (counter checks follow STALL_CNT_EN)
module tb_pipe_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       if_id_Rs;
    logic [2:0]       if_id_Rt;
    logic             if_id_useRs;
    logic             if_id_useRt;
    logic             id_Halt;
    logic             id_ex_MemRead;
    logic             id_ex_RegWrite;
    logic [2:0]       id_ex_writeRegSel;
    logic             ex_Taken;
    logic             ex_mem_MemRead;
    logic             ex_mem_MemWrite;
    logic             mem_Done;
    logic             mem_wb_Halt;
    logic             PCStall;
    logic             IFIDStall;
    logic             FlushIFID;
    logic             Flush;
    logic             DMemStall;
    logic             halt_done;
    logic [CNT_W-1:0] ld_use_cnt;
    logic [CNT_W-1:0] dmem_stall_cnt;
    logic [5:0]       outs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign outs = {PCStall, IFIDStall, FlushIFID, Flush, DMemStall, halt_done};

    pipe_ctrl #(
        .REG_ID_W (3),
        .CNT_W    (CNT_W)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .if_id_Rs          (if_id_Rs),
        .if_id_Rt          (if_id_Rt),
        .if_id_useRs       (if_id_useRs),
        .if_id_useRt       (if_id_useRt),
        .id_Halt           (id_Halt),
        .id_ex_MemRead     (id_ex_MemRead),
        .id_ex_RegWrite    (id_ex_RegWrite),
        .id_ex_writeRegSel (id_ex_writeRegSel),
        .ex_Taken          (ex_Taken),
        .ex_mem_MemRead    (ex_mem_MemRead),
        .ex_mem_MemWrite   (ex_mem_MemWrite),
        .mem_Done          (mem_Done),
        .mem_wb_Halt       (mem_wb_Halt),
        .PCStall           (PCStall),
        .IFIDStall         (IFIDStall),
        .FlushIFID         (FlushIFID),
        .Flush             (Flush),
        .DMemStall         (DMemStall),
        .halt_done         (halt_done),
        .ld_use_cnt        (ld_use_cnt),
        .dmem_stall_cnt    (dmem_stall_cnt)
    );

    // outs = {PCStall, IFIDStall, FlushIFID, Flush, DMemStall, halt_done}

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_id_Rs = 3'd0; if_id_Rt = 3'd0; if_id_useRs = 1'b0; if_id_useRt = 1'b0;
        id_Halt = 1'b0; id_ex_MemRead = 1'b0; id_ex_RegWrite = 1'b0; id_ex_writeRegSel = 3'd0;
        ex_Taken = 1'b0; ex_mem_MemRead = 1'b0; ex_mem_MemWrite = 1'b0; mem_Done = 1'b0;
        mem_wb_Halt = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    task automatic set_ld_use();
        id_ex_MemRead = 1'b1; id_ex_RegWrite = 1'b1; id_ex_writeRegSel = 3'd3;
        if_id_Rs = 3'd3; if_id_useRs = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests++;
        if (outs !== 6'b000000) begin
            $display("FAIL reset_outs got=%b exp=%b", outs, 6'b000000); fails++;
        end
        tests++;
        if (ld_use_cnt !== '0 || dmem_stall_cnt !== '0) begin
            $display("FAIL reset_cnt got=%0d/%0d exp=0/0", ld_use_cnt, dmem_stall_cnt); fails++;
        end
    endtask

    task automatic test_load_use();
        logic [5:0] exp_v [6];
        do_reset();
        exp_v = '{6'b110100, 6'b000000, 6'b110100, 6'b000000, 6'b000000, 6'b000000};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: set_ld_use();
                1: begin end                      // ID/EX now holds a bubble
                2: begin set_ld_use(); if_id_useRs = 1'b0; if_id_Rs = 3'd5;
                         if_id_Rt = 3'd3; if_id_useRt = 1'b1; end
                3: begin set_ld_use(); if_id_useRs = 1'b0; if_id_Rt = 3'd3; end
                4: begin set_ld_use(); id_ex_writeRegSel = 3'd4; end
                default: begin set_ld_use(); id_ex_MemRead = 1'b0; end
            endcase
            @(negedge clk);
            tests++;
            if (outs !== exp_v[i]) begin
                $display("FAIL load_use_%0d got=%b exp=%b", i, outs, exp_v[i]); fails++;
            end
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_branch_beats_ld_use();
        do_reset();
        set_ld_use();
        ex_Taken = 1'b1;
        @(negedge clk);
        tests++;
        if (outs !== 6'b001100) begin
            $display("FAIL branch_beats_ld got=%b exp=%b", outs, 6'b001100); fails++;
        end
        nxt();
        clear_inputs();
    endtask

    task automatic test_dmem_wait();
        int stalls = 0;
        do_reset();
        ex_mem_MemRead = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_Done = (c == 3);
            @(negedge clk);
            if (DMemStall) stalls++;
            nxt();
        end
        tests++;
        if (stalls !== 3) begin
            $display("FAIL dmem_wait_cycles got=%0d exp=3", stalls); fails++;
        end
        clear_inputs();
        @(negedge clk);
        tests++;
        if (DMemStall !== 1'b0) begin
            $display("FAIL dmem_back_idle got=%b exp=0", DMemStall); fails++;
        end
        nxt();
        ex_mem_MemWrite = 1'b1; mem_Done = 1'b1;
        @(negedge clk);
        tests++;
        if (DMemStall !== 1'b0) begin
            $display("FAIL dmem_same_cycle got=%b exp=0", DMemStall); fails++;
        end
        nxt();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (DMemStall !== 1'b0) begin
            $display("FAIL dmem_same_cycle_idle got=%b exp=0", DMemStall); fails++;
        end
        nxt();
    endtask

    task automatic test_back_to_back();
        logic exp_v [4];
        do_reset();
        exp_v = '{1'b1, 1'b0, 1'b1, 1'b0};
        ex_mem_MemRead = 1'b1;
        for (int c = 0; c < 4; c++) begin
            mem_Done = c[0];
            @(negedge clk);
            tests++;
            if (outs !== {exp_v[c], exp_v[c], 2'b00, exp_v[c], 1'b0}) begin
                $display("FAIL back_to_back_%0d got=%b exp_stall=%b", c, outs, exp_v[c]); fails++;
            end
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_halt();
        logic [5:0] exp_v [8];
        do_reset();
        exp_v = '{6'b000000, 6'b100000, 6'b100000, 6'b100000,
                  6'b100001, 6'b100001, 6'b100001, 6'b100001};
        for (int c = 0; c < 8; c++) begin
            id_Halt     = (c == 0);
            mem_wb_Halt = (c == 3);
            @(negedge clk);
            tests++;
            if (outs !== exp_v[c]) begin
                $display("FAIL halt_drain_%0d got=%b exp=%b", c, outs, exp_v[c]); fails++;
            end
            nxt();
        end
        do_reset();
        @(negedge clk);
        tests++;
        if (outs !== 6'b000000) begin
            $display("FAIL halt_reset got=%b exp=%b", outs, 6'b000000); fails++;
        end
    endtask

    task automatic test_halt_ignored();
        do_reset();
        id_Halt = 1'b1; ex_Taken = 1'b1;
        nxt();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (outs !== 6'b000000) begin
            $display("FAIL halt_wrong_path got=%b exp=%b", outs, 6'b000000); fails++;
        end
        id_Halt = 1'b1; ex_mem_MemRead = 1'b1;
        @(negedge clk);
        tests++;
        if (outs !== 6'b110010) begin
            $display("FAIL halt_under_dmem got=%b exp=%b", outs, 6'b110010); fails++;
        end
        nxt();
        id_Halt = 1'b0; mem_Done = 1'b1;
        @(negedge clk);
        tests++;
        if (outs !== 6'b000000) begin
            $display("FAIL halt_under_dmem_run got=%b exp=%b", outs, 6'b000000); fails++;
        end
        nxt();
        clear_inputs();
        id_Halt = 1'b1;
        nxt();
        clear_inputs();
        mem_wb_Halt = 1'b1; ex_mem_MemRead = 1'b1;
        nxt();
        mem_wb_Halt = 1'b0; mem_Done = 1'b1;
        nxt();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (outs !== 6'b100000) begin
            $display("FAIL drain_blocked_by_dmem got=%b exp=%b", outs, 6'b100000); fails++;
        end
        mem_wb_Halt = 1'b1;
        nxt();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (outs !== 6'b100001) begin
            $display("FAIL drain_then_halt got=%b exp=%b", outs, 6'b100001); fails++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        id_Halt = 1'b1;
        nxt();
        clear_inputs();
        ex_mem_MemRead = 1'b1;
        @(negedge clk);
        tests++;
        if (outs !== 6'b110010) begin
            $display("FAIL mid_busy_drain got=%b exp=%b", outs, 6'b110010); fails++;
        end
        nxt();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        tests++;
        if (outs !== 6'b000000) begin
            $display("FAIL reset_mid got=%b exp=%b", outs, 6'b000000); fails++;
        end
        nxt();
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] exp_ld;
        logic [CNT_W-1:0] exp_dm;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_ld_use();
            nxt();
            clear_inputs();
            nxt();
        end
        ex_mem_MemRead = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mem_Done = (c == 4);
            nxt();
        end
        clear_inputs();
        @(negedge clk);
`ifdef STALL_CNT_EN
        exp_ld = 4'd2; exp_dm = 4'd4;
`else
        exp_ld = '0; exp_dm = '0;
`endif
        tests++;
        if (ld_use_cnt !== exp_ld || dmem_stall_cnt !== exp_dm) begin
            $display("FAIL cnt_basic got=%0d/%0d exp=%0d/%0d", ld_use_cnt, dmem_stall_cnt, exp_ld, exp_dm);
            fails++;
        end
        set_ld_use();
        for (int c = 0; c < 20; c++) nxt();
        clear_inputs();
        ex_mem_MemWrite = 1'b1;
        for (int c = 0; c < 20; c++) nxt();
        mem_Done = 1'b1;
        nxt();
        clear_inputs();
        @(negedge clk);
`ifdef STALL_CNT_EN
        exp_ld = '1; exp_dm = '1;
`endif
        tests++;
        if (ld_use_cnt !== exp_ld || dmem_stall_cnt !== exp_dm) begin
            $display("FAIL cnt_saturate got=%0d/%0d exp=%0d/%0d", ld_use_cnt, dmem_stall_cnt, exp_ld, exp_dm);
            fails++;
        end
        do_reset();
        id_Halt = 1'b1;
        nxt();
        clear_inputs();
        mem_wb_Halt = 1'b1;
        nxt();
        clear_inputs();
        set_ld_use();
        for (int c = 0; c < 3; c++) nxt();
        clear_inputs();
        @(negedge clk);
        tests++;
        if (ld_use_cnt !== '0 || halt_done !== 1'b1) begin
            $display("FAIL cnt_frozen_halted got=%0d/%b exp=0/1", ld_use_cnt, halt_done); fails++;
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_load_use();
        test_branch_beats_ld_use();
        test_dmem_wait();
        test_back_to_back();
        test_halt();
        test_halt_ignored();
        test_reset_mid();
        test_counters();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
